// File: rtl/muldiv_hilo_unit_pkg.sv
// muldiv_hilo_unit_pkg: opcodes, FSM states and sign helper shared by the HI/LO unit
package muldiv_hilo_unit_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_t;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  // two's-complement negate when neg is set; callers zero-extend in and truncate out
  function automatic logic [2*MAX_W-1:0] cneg(input logic neg, input logic [2*MAX_W-1:0] v);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// muldiv_hilo_unit_if: op issue, HI/LO read and status bus of the multiply/divide unit
interface muldiv_hilo_unit_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  modport master (output op_valid, op, a, b, flush, rd_req, input hi, lo, busy, done, stall);
  modport slave (input op_valid, op, a, b, flush, rd_req, output hi, lo, busy, done, stall);
endinterface

// File: rtl/muldiv_hilo_unit_step.sv
// muldiv_hilo_unit_step: one restoring-divide or shift-add iteration on the {hi,lo} work pair
module muldiv_hilo_unit_step #(parameter int WIDTH = 32) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_sum, w_shl, w_dif;
  // divide shifts the dividend MSB into the remainder; multiply adds and shifts right LSB-first
  always_comb begin
    w_sum = {1'b0, i_hi} + {1'b0, i_m & {WIDTH{i_lo[0]}}};
    w_shl = {i_hi, i_lo[WIDTH-1]};
    w_dif = w_shl - {1'b0, i_m};
    o_hi = i_div ? (w_dif[WIDTH] ? w_shl[WIDTH-1:0] : w_dif[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_lo = i_div ? {i_lo[WIDTH-2:0], ~w_dif[WIDTH]} : {w_sum[0], i_lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide engine owning the HI/LO register pair
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic clock,
  input logic reset,
  muldiv_hilo_unit_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;
  localparam int TW = 2 * MAX_W;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  if (WIDTH % STEP != 0 || (STEP != 1 && STEP != 2 && STEP != 4) || WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("muldiv_hilo_unit: unsupported WIDTH/STEP combination");
  end
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_hi, r_lo, r_ph, r_pl, r_m, w_ma, w_mb;
  logic             r_nq, r_nr, w_acc, w_it, w_div, w_dz, w_na, w_nb, w_busy, w_done, w_rdiv;
  logic [W2-1:0]    w_sp, w_res;
  logic [WIDTH-1:0] w_ch [STEP+1];
  logic [WIDTH-1:0] w_cl [STEP+1];
  // accept decode and operand magnitudes for the unsigned core
  always_comb begin
    w_acc = r_state == IDLE && bus.op_valid && !bus.flush;
    w_it  = w_acc && !bus.op[3];
    w_div = bus.op[2:1] == 2'b01;
    w_dz  = w_div && bus.b == '0;
    w_na  = !bus.op[0] && bus.a[WIDTH-1];
    w_nb  = !bus.op[0] && bus.b[WIDTH-1];
    w_ma  = WIDTH'(cneg(w_na, TW'(bus.a)));
    w_mb  = WIDTH'(cneg(w_nb, TW'(bus.b)));
  end
  // state register
  always_ff @(posedge clock) r_state <= reset ? IDLE : w_next;
  // next state: flush always wins, divide-by-zero skips the iterations
  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = IDLE;
    else if (r_state == IDLE) w_next = w_it ? (w_dz ? FINISH : RUN) : IDLE;
    else if (r_state == RUN) w_next = r_cnt == '0 ? FINISH : RUN;
    else w_next = IDLE;
  end
  // FSM outputs: busy spans RUN and FINISH, commit is suppressed by flush
  always_comb begin
    w_busy = r_state != IDLE;
    w_done = r_state == FINISH && !bus.flush;
  end
  // signed result fix-up and accumulate applied in FINISH
  always_comb begin
    w_rdiv = r_mode == 2'b01;
    w_sp   = W2'(cneg(r_nq, TW'({r_ph, r_pl})));
    w_res  = w_rdiv ? {WIDTH'(cneg(r_nr, TW'(r_ph))), WIDTH'(cneg(r_nq, TW'(r_pl)))}
           : r_mode == 2'b10 ? {r_hi, r_lo} + w_sp
           : r_mode == 2'b11 ? {r_hi, r_lo} - w_sp : w_sp;
  end
  assign w_ch[0] = r_ph;
  assign w_cl[0] = r_pl;
  for (genvar i = 0; i < STEP; i++) begin : g_step
    muldiv_hilo_unit_step #(.WIDTH(WIDTH)) u_step (
      .i_div(w_rdiv), .i_hi(w_ch[i]), .i_lo(w_cl[i]), .i_m(r_m), .o_hi(w_ch[i+1]), .o_lo(w_cl[i+1])
    );
  end
  // operand latch, iteration datapath and HI/LO writes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc && bus.op == OP_MTHI) r_hi <= bus.a;
      if (w_acc && bus.op == OP_MTLO) r_lo <= bus.a;
      if (w_it) begin
        r_mode <= bus.op[2:1];
        r_ph   <= w_dz ? bus.a : '0;
        r_pl   <= w_dz ? '1 : w_div ? w_ma : w_mb;
        r_m    <= w_div ? w_mb : w_ma;
        r_nq   <= !w_dz && (w_na ^ w_nb);
        r_nr   <= !w_dz && w_na;
        r_cnt  <= C_LAST;
      end else if (r_state == RUN) begin
        r_ph  <= w_ch[STEP];
        r_pl  <= w_cl[STEP];
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done) {r_hi, r_lo} <= w_res;
    end
  end
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.stall = w_busy && (bus.rd_req || bus.op_valid);
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: randomized self-checking bench against a 64-bit arithmetic model
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [2];
  always #5 clock = ~clock;
  muldiv_hilo_unit_if #(.WIDTH(32)) m1 ();
  muldiv_hilo_unit_if #(.WIDTH(32)) m4 ();
  muldiv_hilo_unit #(.WIDTH(32), .STEP(1)) u1 (.clock(clock), .reset(reset), .bus(m1.slave));
  muldiv_hilo_unit #(.WIDTH(32), .STEP(4)) u4 (.clock(clock), .reset(reset), .bus(m4.slave));

  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
    logic [63:0] sp, up;
    sp = 64'(longint'($signed(a)) * longint'($signed(b)));
    up = {32'h0, a} * {32'h0, b};
    if (op == OP_MTHI) return {a, hl[31:0]};
    if (op == OP_MTLO) return {hl[63:32], a};
    if (op > 4'd9) return hl;
    if (op == OP_MULT) return sp;
    if (op == OP_MULTU) return up;
    if (op == OP_MADD) return hl + sp;
    if (op == OP_MADDU) return hl + up;
    if (op == OP_MSUB) return hl - sp;
    if (op == OP_MSUBU) return hl - up;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIVU) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  function automatic int ebusy(input bit s, input logic [3:0] op, input logic [31:0] b);
    if (op > 4'd7) return 0;
    if ((op == OP_DIV || op == OP_DIVU) && b == 32'h0) return 1;
    return s ? 9 : 33;
  endfunction

  function automatic logic [63:0] hl(input bit s);
    return s ? {m4.hi, m4.lo} : {m1.hi, m1.lo};
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? m4.busy : m1.busy;
  endfunction
  function automatic logic done_of(input bit s);
    return s ? m4.done : m1.done;
  endfunction
  function automatic logic stall_of(input bit s);
    return s ? m4.stall : m1.stall;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit s, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rd, input logic fl);
    if (s) begin
      m4.op_valid = v; m4.op = op; m4.a = a; m4.b = b; m4.rd_req = rd; m4.flush = fl;
    end else begin
      m1.op_valid = v; m1.op = op; m1.a = a; m1.b = b; m1.rd_req = rd; m1.flush = fl;
    end
  endtask

  task automatic do_op(input bit s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int bc, output int dn);
    drive(s, 1'b1, op, a, b, 1'b0, 1'b0);
    tick();
    drive(s, 1'b0, op, a, b, 1'b0, 1'b0);
    mdl[s] = ref_op(op, a, b, mdl[s]);
    bc = 0;
    dn = 0;
    while (busy_of(s) && bc < 100) begin
      bc++;
      if (done_of(s)) dn++;
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    mdl[0] = 64'h0;
    mdl[1] = 64'h0;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (hl(s[0]) !== 64'h0) begin errors++; $display("FAIL reset_hilo s%0d got %h expected 0", s, hl(s[0])); end
      checks++;
      if ({busy_of(s[0]), done_of(s[0]), stall_of(s[0])} !== 3'b000)
        begin errors++; $display("FAIL reset_status s%0d busy/done/stall got %b expected 000", s, {busy_of(s[0]), done_of(s[0]), stall_of(s[0])}); end
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_multu_max();
    int bc, dn;
    do_op(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn);
    checks++;
    if (bc != 33 || dn != 1) begin errors++; $display("FAIL multu_timing busy=%0d done=%0d expected 33/1", bc, dn); end
    checks++;
    if (hl(1'b0) !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got %h expected fffffffe00000001", hl(1'b0)); end
  endtask

  task automatic test_mac_chain();
    logic [3:0]  ops [3] = '{OP_MULT, OP_MADD, OP_MSUBU};
    logic [31:0] as [3]  = '{32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFF1};
    logic [31:0] bs [3]  = '{32'd7, 32'd3, 32'd1};
    logic [63:0] ex [3]  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_0000_0000};
    int bc, dn;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, ops[i], as[i], bs[i], bc, dn);
      checks++;
      if (hl(1'b0) !== ex[i] || bc != 33 || dn != 1)
        begin errors++; $display("FAIL mac_chain[%0d] got %h busy=%0d done=%0d expected %h 33/1", i, hl(1'b0), bc, dn, ex[i]); end
    end
  endtask

  task automatic test_div_table();
    logic [3:0]  ops [4] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as [4]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9};
    logic [31:0] bs [4]  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [63:0] ex [4]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000, 64'h0000_0064_FFFF_FFFF, 64'hFFFF_FFF9_FFFF_FFFF};
    int          eb [4]  = '{33, 33, 1, 1};
    int bc, dn;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, ops[i], as[i], bs[i], bc, dn);
      checks++;
      if (hl(1'b0) !== ex[i]) begin errors++; $display("FAIL div_table[%0d] got %h expected %h", i, hl(1'b0), ex[i]); end
      checks++;
      if (bc != eb[i] || dn != 1) begin errors++; $display("FAIL div_timing[%0d] busy=%0d done=%0d expected %0d/1", i, bc, dn, eb[i]); end
    end
  endtask

  task automatic test_stall(input bit s);
    int bc = 0;
    drive(s, 1'b1, OP_DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
    tick();
    drive(s, 1'b0, OP_DIVU, 32'd1000, 32'd7, 1'b1, 1'b0);
    #1;
    mdl[s] = ref_op(OP_DIVU, 32'd1000, 32'd7, mdl[s]);
    while (busy_of(s) && bc < 100) begin
      bc++;
      checks++;
      if (stall_of(s) !== 1'b1) begin errors++; $display("FAIL stall_busy s%0d cycle %0d got %b expected 1", s, bc, stall_of(s)); end
      tick();
    end
    checks++;
    if (stall_of(s) !== 1'b0 || bc != (s ? 9 : 33))
      begin errors++; $display("FAIL stall_end s%0d stall=%b busy=%0d expected 0 and %0d", s, stall_of(s), bc, s ? 9 : 33); end
    checks++;
    if (hl(s) !== {32'd6, 32'd142}) begin errors++; $display("FAIL stall_result s%0d got %h expected %h", s, hl(s), {32'd6, 32'd142}); end
    drive(s, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_mthi_busy();
    logic [31:0] a = $urandom;
    logic [31:0] b = 32'($urandom_range(1, 1000));
    int bc = 0;
    drive(1'b0, 1'b1, OP_DIVU, a, b, 1'b0, 1'b0);
    tick();
    mdl[0] = ref_op(OP_DIVU, a, b, mdl[0]);
    drive(1'b0, 1'b1, OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0);
    #1;
    while (m1.busy && bc < 100) begin
      bc++;
      checks++;
      if (m1.stall !== 1'b1) begin errors++; $display("FAIL mthi_stall cycle %0d got %b expected 1", bc, m1.stall); end
      tick();
    end
    checks++;
    if (hl(1'b0) !== mdl[0]) begin errors++; $display("FAIL mthi_early got %h expected %h", hl(1'b0), mdl[0]); end
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    mdl[0] = ref_op(OP_MTHI, 32'h1234, 32'h0, mdl[0]);
    checks++;
    if ({hl(1'b0), m1.busy} !== {mdl[0], 1'b0}) begin errors++; $display("FAIL mthi_apply got %h busy=%b expected %h busy=0", hl(1'b0), m1.busy, mdl[0]); end
  endtask

  task automatic test_flush();
    int dn = 0;
    drive(1'b0, 1'b1, OP_DIVU, $urandom, 32'($urandom_range(1, 99)), 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (9) begin
      if (m1.done) dn++;
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    if (m1.done) dn++;
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (m1.busy !== 1'b0) begin errors++; $display("FAIL flush_run busy got %b expected 0", m1.busy); end
    repeat (3) begin
      if (m1.done || m1.busy) dn++;
      tick();
    end
    checks++;
    if (dn != 0 || hl(1'b0) !== mdl[0]) begin errors++; $display("FAIL flush_run_hilo got %h events=%0d expected %h events=0", hl(1'b0), dn, mdl[0]); end
    drive(1'b0, 1'b1, OP_DIVU, $urandom, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({m1.busy, m1.done} !== 2'b10) begin errors++; $display("FAIL flush_finish busy/done got %b expected 10", {m1.busy, m1.done}); end
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({hl(1'b0), m1.busy} !== {mdl[0], 1'b0}) begin errors++; $display("FAIL flush_finish_hilo got %h busy=%b expected %h busy=0", hl(1'b0), m1.busy, mdl[0]); end
  endtask

  task automatic test_flush_idle();
    drive(1'b0, 1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, OP_MULT, 32'd3, 32'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({hl(1'b0), m1.busy} !== {mdl[0], 1'b0}) begin errors++; $display("FAIL flush_idle got %h busy=%b expected %h busy=0", hl(1'b0), m1.busy, mdl[0]); end
  endtask

  task automatic test_random(input bit s, input int n);
    logic [3:0] op;
    logic [31:0] a, b;
    int bc, dn, eb;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      eb = ebusy(s, op, b);
      do_op(s, op, a, b, bc, dn);
      checks++;
      if (bc != eb || dn != (eb > 0 ? 1 : 0))
        begin errors++; $display("FAIL rand_timing s%0d op=%0d busy=%0d done=%0d expected busy=%0d", s, op, bc, dn, eb); end
      checks++;
      if (hl(s) !== mdl[s])
        begin errors++; $display("FAIL rand_hilo s%0d op=%0d a=%h b=%h got %h expected %h", s, op, a, b, hl(s), mdl[s]); end
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 1'b1, OP_MULT, $urandom, $urandom, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) tick();
    checks++;
    if (m1.busy !== 1'b1) begin errors++; $display("FAIL reset_midop_pre busy got %b expected 1", m1.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl[0] = 64'h0;
    mdl[1] = 64'h0;
    checks++;
    if ({hl(1'b0), m1.busy, m1.done} !== 66'h0) begin errors++; $display("FAIL reset_midop got %h busy=%b done=%b expected 0", hl(1'b0), m1.busy, m1.done); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mac_chain();
    test_div_table();
    test_stall(1'b0);
    test_stall(1'b1);
    test_mthi_busy();
    test_flush();
    test_flush_idle();
    test_random(1'b0, 40);
    test_random(1'b1, 25);
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
